hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage core's execute stage. It generates the operand-forwarding selects for the execute operand muxes and detects load-use hazards. It also issues branch/jump flushes. A small FSM sequences multi-cycle execute operations: it holds fetch/decode/execute and bubbles the memory stage until the operation completes.

Parameters:
MC_LATENCY, 4, total cycles a multi-cycle op occupies execute (legal range 1..16; 1 = never stalls)
CNT_W, 4, width of internal countdown counter (must hold MC_LATENCY-1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
rs1_addr_D  input  5  decode-stage source 1 register index
rs2_addr_D  input  5  decode-stage source 2 register index
rs1_addr_E  input  5  execute-stage source 1 register index
rs2_addr_E  input  5  execute-stage source 2 register index
rd_addr_E  input  5  execute-stage destination index
rd_addr_M  input  5  memory-stage destination index
rd_addr_W  input  5  writeback-stage destination index
RegWriteM  input  1  memory-stage register write enable
RegWriteW  input  1  writeback-stage register write enable
ResultSrcE  input  2  execute-stage result source; 2'b01 = load
PCSrcE  input  1  branch taken / jump resolved in execute
mc_start_E  input  1  execute stage holds a multi-cycle op
ForwardAE  output  2  operand A select: 00 register, 01 ResultW, 10 ALUResultM
ForwardBE  output  2  operand B select, same encoding
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register (insert bubble)
FlushM  output  1  clear EX/MEM register (insert bubble)
mc_capture  output  1  one-cycle pulse: execute latches forwarded SrcA/SrcB into the multi-cycle unit
mc_busy  output  1  FSM in RUN state
mc_done  output  1  one-cycle pulse: final cycle of multi-cycle op, result valid in execute

Behaviour:
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM & rd_addr_M!=0 & rd_addr_M==rs1_addr_E.
  - Otherwise ForwardAE = 01 if RegWriteW & rd_addr_W!=0 & rd_addr_W==rs1_addr_E.
  - Otherwise ForwardAE = 00.
  - ForwardBE is identical using rs2_addr_E.
  - M has priority over W. x0 is never forwarded. Forwarding is computed in every state.
- Load-use hazard:
  - lu = (ResultSrcE==01) & rd_addr_E!=0 & (rd_addr_E==rs1_addr_D | rd_addr_E==rs2_addr_D).
  - lu asserts StallF, StallD and FlushE.
- Branch/jump: PCSrcE asserts FlushD and FlushE. PCSrcE has priority over lu: when both are true, StallF and StallD are 0.
- FSM states: IDLE, RUN. Counter cnt is CNT_W bits.
  - IDLE & mc_start_E & MC_LATENCY>1: mc_capture=1, stalls asserted this cycle, cnt<=MC_LATENCY-2, next=RUN.
  - IDLE & mc_start_E & MC_LATENCY==1: mc_done=1, no stall, stay IDLE.
  - RUN & cnt!=0: cnt<=cnt-1, stay RUN.
  - RUN & cnt==0: mc_done=1, no stall, next=IDLE. mc_start_E is ignored in RUN, because the same op is still in execute.
  - Mc-stall = (IDLE & mc_start_E & MC_LATENCY>1) | (RUN & cnt!=0). Mc-stall asserts StallF, StallD, StallE and FlushM.
  - Result: MC_LATENCY cycles in execute, MC_LATENCY-1 stall cycles.
- Priority:
  - During mc-stall, PCSrcE and lu are masked, so FlushD=FlushE=0. The op in execute is not a branch, and decode is frozen.
  - The branch/lu terms apply normally on the mc_done cycle.
- mc_busy = (state==RUN).
- Back-to-back multi-cycle ops: a new mc_start_E seen in IDLE on the cycle after mc_done starts a fresh sequence.
- Reset (rst=0, async): state=IDLE, cnt=0. All outputs then follow the combinational IDLE equations; with inputs at 0, all outputs are 0. Reset mid-RUN aborts the op immediately, with no mc_done.

Test Plan:
- Set rd_addr_M=5, RegWriteM=1, rd_addr_W=5, RegWriteW=1, rs1_addr_E=5, rs2_addr_E=0 -> ForwardAE=10, ForwardBE=00; clear RegWriteM -> ForwardAE=01.
- Set ResultSrcE=01, rd_addr_E=7, rs2_addr_D=7 -> StallF=StallD=FlushE=1 for exactly that cycle; change rd_addr_E to 0 -> all low.
- Load-use hazard plus PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
- MC_LATENCY=4, pulse mc_start_E held for 4 cycles from T0:
  - T0: mc_capture=1.
  - T0..T2: StallF/D/E=1 and FlushM=1.
  - T1..T3: mc_busy=1.
  - T3: mc_done=1, stalls low.
  - T4: IDLE.
- Two consecutive multi-cycle ops (mc_start_E high for 8 cycles) -> mc_capture at T0 and T4, mc_done at T3 and T7, stall gap only at T3.
- Deassert rst at T1 of a multi-cycle sequence -> outputs drop asynchronously, no mc_done; after release, state=IDLE.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Execute-stage hazard controller bus: pipeline register indices and enables
// in, forwarding selects and stall/flush/multi-cycle controls out.
interface hazard_ctrl_if;
    logic [4:0] rs1_addr_D;
    logic [4:0] rs2_addr_D;
    logic [4:0] rs1_addr_E;
    logic [4:0] rs2_addr_E;
    logic [4:0] rd_addr_E;
    logic [4:0] rd_addr_M;
    logic [4:0] rd_addr_W;
    logic       RegWriteM;
    logic       RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE;
    logic       mc_start_E;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       FlushD;
    logic       FlushE;
    logic       FlushM;
    logic       mc_capture;
    logic       mc_busy;
    logic       mc_done;

    modport master (
        output rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
               rd_addr_E, rd_addr_M, rd_addr_W, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, mc_start_E,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, mc_capture, mc_busy, mc_done
    );

    modport slave (
        input  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
               rd_addr_E, rd_addr_M, rd_addr_W, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, mc_start_E,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, mc_capture, mc_busy, mc_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the execute stage: forwarding selects,
// load-use stalls, branch flushes and a multi-cycle op sequencer.
module hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT =
        (MC_LATENCY > 1) ? CNT_W'(MC_LATENCY - 2) : '0;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             lu, mc_go, mc_stall;

    always_comb begin
        hz.ForwardAE = 2'b00;
        if (hz.RegWriteM && hz.rd_addr_M != 5'd0 && hz.rd_addr_M == hz.rs1_addr_E)
            hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && hz.rd_addr_W != 5'd0 && hz.rd_addr_W == hz.rs1_addr_E)
            hz.ForwardAE = 2'b01;
    end

    always_comb begin
        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && hz.rd_addr_M != 5'd0 && hz.rd_addr_M == hz.rs2_addr_E)
            hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && hz.rd_addr_W != 5'd0 && hz.rd_addr_W == hz.rs2_addr_E)
            hz.ForwardBE = 2'b01;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (hz.mc_start_E && MC_LATENCY > 1) begin
                    state_next = RUN;
                    cnt_next   = CNT_INIT;
                end
            end
            RUN: begin
                if (cnt != '0)
                    cnt_next = cnt - CNT_W'(1);
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Multi-cycle stall masks branch and load-use terms: decode is frozen and
    // the op holding execute is never a branch.
    always_comb begin
        lu = (hz.ResultSrcE == 2'b01) && (hz.rd_addr_E != 5'd0) &&
             ((hz.rd_addr_E == hz.rs1_addr_D) || (hz.rd_addr_E == hz.rs2_addr_D));
        mc_go    = (state == IDLE) && hz.mc_start_E && (MC_LATENCY > 1);
        mc_stall = mc_go || ((state == RUN) && (cnt != '0));

        hz.mc_capture = mc_go;
        hz.mc_busy    = (state == RUN);
        hz.mc_done    = ((state == IDLE) && hz.mc_start_E && (MC_LATENCY == 1)) ||
                        ((state == RUN) && (cnt == '0));

        hz.StallF = mc_stall || (lu && !hz.PCSrcE);
        hz.StallD = mc_stall || (lu && !hz.PCSrcE);
        hz.StallE = mc_stall;
        hz.FlushM = mc_stall;
        hz.FlushD = !mc_stall && hz.PCSrcE;
        hz.FlushE = !mc_stall && (hz.PCSrcE || lu);
    end

endmodule
